// File: rtl/piso_serializer.sv
// Parallel-in, serial-out serializer: a word accepted through a valid/ready load
// handshake is streamed out on Q (registered), one bit per Shift_en strobe.
module piso_serializer #(
    parameter int WIDTH     = 8,
    parameter bit LSB_FIRST = 1'b0
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic [WIDTH-1:0] Din,
    input  logic             Load_valid,
    output logic             Load_ready,
    input  logic             Shift_en,
    output logic             Q,
    output logic             Qn,
    output logic             Busy,
    output logic             Done
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_shift;
    logic [CW-1:0]    r_cnt;
    logic             r_q;
    logic             r_done;

    logic [WIDTH-1:0] w_shifted;
    logic             w_first_bit;
    logic             w_next_bit;
    logic             w_accept;

    // The shift register keeps the bit currently on Q at its output end, so the
    // following bit is always the neighbour one position further in.
    generate
        if (LSB_FIRST) begin : g_lsb_first
            assign w_shifted   = r_shift >> 1;
            assign w_first_bit = Din[0];
            assign w_next_bit  = r_shift[1];
        end else begin : g_msb_first
            assign w_shifted   = r_shift << 1;
            assign w_first_bit = Din[WIDTH-1];
            assign w_next_bit  = r_shift[WIDTH-2];
        end
    endgenerate

    assign Load_ready = (r_state == ST_IDLE) && Rst_n;
    assign w_accept   = Load_valid && Load_ready;

    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            r_state <= ST_IDLE;
            r_shift <= '0;
            r_cnt   <= '0;
            r_q     <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (r_state == ST_IDLE) begin
                if (w_accept) begin
                    r_shift <= Din;
                    r_cnt   <= LAST_IDX;
                    r_q     <= w_first_bit;
                    r_state <= ST_SHIFT;
                end
            end else if (Shift_en) begin
                if (r_cnt != '0) begin
                    r_shift <= w_shifted;
                    r_q     <= w_next_bit;
                    r_cnt   <= r_cnt - 1'b1;
                end else begin
                    // Final strobe consumes the last bit; the word is finished.
                    r_shift <= '0;
                    r_q     <= 1'b0;
                    r_done  <= 1'b1;
                    r_state <= ST_IDLE;
                end
            end
        end
    end

    assign Q    = r_q;
    assign Qn   = ~r_q;
    assign Busy = (r_state == ST_SHIFT);
    assign Done = r_done;

endmodule

// File: tb/tb_piso_serializer.sv
// Self-checking bench for piso_serializer: MSB-first and LSB-first instances share
// stimulus and are compared every cycle against a word/bit-index model.
module tb_piso_serializer;
    localparam int W = 8;

    logic         Clk = 1'b0;
    logic         Rst_n = 1'b0;
    logic         Load_valid = 1'b0;
    logic         Shift_en = 1'b0;
    logic [W-1:0] Din = '0;

    logic m_ready, m_q, m_qn, m_busy, m_done;
    logic l_ready, l_q, l_qn, l_busy, l_done;

    piso_serializer #(.WIDTH(W), .LSB_FIRST(1'b0)) u_msb (
        .Clk(Clk), .Rst_n(Rst_n), .Din(Din), .Load_valid(Load_valid),
        .Load_ready(m_ready), .Shift_en(Shift_en), .Q(m_q), .Qn(m_qn),
        .Busy(m_busy), .Done(m_done)
    );

    piso_serializer #(.WIDTH(W), .LSB_FIRST(1'b1)) u_lsb (
        .Clk(Clk), .Rst_n(Rst_n), .Din(Din), .Load_valid(Load_valid),
        .Load_ready(l_ready), .Shift_en(Shift_en), .Q(l_q), .Qn(l_qn),
        .Busy(l_busy), .Done(l_done)
    );

    always #5 Clk = ~Clk;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    // Model: a word is in flight with k strobes already consumed.
    bit           md_busy = 1'b0;
    bit           md_done = 1'b0;
    int           md_k = 0;
    logic [W-1:0] md_word = '0;

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk8(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic exp_q(input bit lsb);
        int idx;
        if (!md_busy) return 1'b0;
        idx = lsb ? md_k : (W - 1 - md_k);
        return md_word[idx];
    endfunction

    task automatic model_step();
        if (!Rst_n) begin
            md_busy = 1'b0;
            md_done = 1'b0;
            md_k    = 0;
        end else begin
            md_done = 1'b0;
            if (!md_busy) begin
                if (Load_valid) begin
                    md_busy = 1'b1;
                    md_word = Din;
                    md_k    = 0;
                end
            end else if (Shift_en) begin
                md_k++;
                if (md_k == W) begin
                    md_busy = 1'b0;
                    md_done = 1'b1;
                    md_k    = 0;
                    $display("TX word=%h sent", md_word);
                end
            end
        end
    endtask

    task automatic cyc();
        @(posedge Clk);
        model_step();
        #1;
    endtask

    always @(negedge Clk) begin
        if (chk_en) begin
            chk1("msb_q",     m_q,     exp_q(1'b0));
            chk1("msb_qn",    m_qn,    ~exp_q(1'b0));
            chk1("msb_busy",  m_busy,  md_busy);
            chk1("msb_done",  m_done,  md_done);
            chk1("msb_ready", m_ready, !md_busy && Rst_n);
            chk1("lsb_q",     l_q,     exp_q(1'b1));
            chk1("lsb_qn",    l_qn,    ~exp_q(1'b1));
            chk1("lsb_busy",  l_busy,  md_busy);
            chk1("lsb_done",  l_done,  md_done);
            chk1("lsb_ready", l_ready, !md_busy && Rst_n);
        end
    end

    // Load one word, then strobe every 'period' cycles; returns both streams with
    // the first transmitted bit in bit W-1. Ends in the Done cycle.
    task automatic send(input logic [W-1:0] word, input int period, input bit inject,
                        output logic [W-1:0] ms, output logic [W-1:0] ls);
        Load_valid = 1'b1;
        Din        = word;
        Shift_en   = 1'b1;
        cyc();
        Load_valid = 1'b0;
        Shift_en   = 1'b0;
        for (int b = 0; b < W; b++) begin
            ms[W-1-b] = m_q;
            ls[W-1-b] = l_q;
            if (inject && b == 3) begin
                Load_valid = 1'b1;
                Din        = 8'hFF;
                chk1("inject_ready", m_ready, 1'b0);
            end
            for (int g = 0; g < period; g++) begin
                Shift_en = (g == period - 1);
                cyc();
            end
            Shift_en   = 1'b0;
            Load_valid = 1'b0;
        end
        chk1("done_pulse_msb", m_done, 1'b1);
        chk1("done_pulse_lsb", l_done, 1'b1);
        chk1("done_ready", m_ready, 1'b1);
    endtask

    initial begin
        logic [W-1:0] ms;
        logic [W-1:0] ls;

        // Reset with a load being offered: nothing may be captured.
        Rst_n = 1'b0; Load_valid = 1'b1; Din = 8'hFF; Shift_en = 1'b1;
        cyc();
        chk_en = 1'b1;
        cyc();
        chk1("rst_q", m_q, 1'b0);
        chk1("rst_qn", m_qn, 1'b1);
        chk1("rst_ready", m_ready, 1'b0);
        chk1("rst_busy", l_busy, 1'b0);
        Rst_n = 1'b1; Load_valid = 1'b0; Shift_en = 1'b0;
        cyc();
        chk1("release_ready", m_ready, 1'b1);
        chk1("release_busy", m_busy, 1'b0);

        send(8'h1E, 1, 1'b0, ms, ls);
        chk8("msb_1E_cont", ms, 8'h1E);
        chk8("lsb_1E_cont", ls, 8'h78);
        cyc();

        send(8'h1E, 3, 1'b0, ms, ls);
        chk8("msb_1E_gap", ms, 8'h1E);
        chk8("lsb_1E_gap", ls, 8'h78);
        cyc();

        // Ignored mid-word load, then back-to-back load in the Done cycle.
        send(8'h1E, 2, 1'b1, ms, ls);
        chk8("msb_1E_inject", ms, 8'h1E);
        chk8("lsb_1E_inject", ls, 8'h78);
        send(8'hA0, 1, 1'b0, ms, ls);
        chk8("msb_A0_b2b", ms, 8'hA0);
        chk8("lsb_A0_b2b", ls, 8'h05);
        cyc();

        // Reset after the third strobe discards the word with no Done.
        Load_valid = 1'b1; Din = 8'h1E;
        cyc();
        Load_valid = 1'b0; Shift_en = 1'b1;
        for (int i = 0; i < 3; i++) cyc();
        Shift_en = 1'b0; Rst_n = 1'b0;
        cyc();
        Rst_n = 1'b1;
        chk1("midrst_busy", m_busy, 1'b0);
        chk1("midrst_q", m_q, 1'b0);
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk1("midrst_no_done", m_done, 1'b0);
        end
        send(8'h81, 1, 1'b0, ms, ls);
        chk8("msb_81", ms, 8'h81);
        chk8("lsb_81", ls, 8'h81);
        cyc();

        // Random traffic with occasional resets, checked by the compare process.
        for (int i = 0; i < 3000; i++) begin
            Rst_n      = ($urandom_range(0, 79) != 0);
            Load_valid = $urandom_range(0, 1) != 0;
            Din        = W'($urandom);
            Shift_en   = $urandom_range(0, 3) != 0;
            cyc();
        end

        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
